// File: rtl/reg_file_sb_if.sv
// Decode-stage register file bus: writeback, read ports and issue/scoreboard signals.
// The master modport is the Decode/Writeback side; the slave modport is the register file.
interface reg_file_sb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   localparam int unsigned NREGS = 1 << ADDR_W;

   logic              reg_write;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] write_data;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic              rs_used;
   logic              rt_used;
   logic [DATA_W-1:0] read_data1;
   logic [DATA_W-1:0] read_data2;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rd;
   logic              issue_wr;
   logic              flush;
   logic              stall;
   logic [NREGS-1:0]  busy_vec;

   modport master (
      output reg_write, rd, write_data, rs, rt, rs_used, rt_used,
             issue_valid, issue_rd, issue_wr, flush,
      input  read_data1, read_data2, stall, busy_vec
   );

   modport slave (
      input  reg_write, rd, write_data, rs, rt, rs_used, rt_used,
             issue_valid, issue_rd, issue_wr, flush,
      output read_data1, read_data2, stall, busy_vec
   );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised two-read/one-write register file with optional hardwired zero register,
// write-to-read bypass and a per-register busy scoreboard that stalls on RAW/WAW hazards.
module reg_file_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   reg_file_sb_if.slave bus
);
   localparam int unsigned NREGS = 1 << ADDR_W;

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [NREGS-1:0]  r_busy;
   logic [NREGS-1:0]  w_busy_nxt;
   logic [NREGS-1:0]  w_eb;
   logic              w_wr_en;
   logic              w_stall;
   logic              w_accept;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   assign w_wr_en = bus.reg_write && !(ZERO_REG && (bus.rd == '0));

   // Read ports: zero register first, then same-cycle writeback, then storage
   always_comb begin
      w_rd1 = r_regs[bus.rs];
      if (BYPASS && bus.reg_write && (bus.rd == bus.rs)) w_rd1 = bus.write_data;
      if (ZERO_REG && (bus.rs == '0))                     w_rd1 = '0;
   end

   always_comb begin
      w_rd2 = r_regs[bus.rt];
      if (BYPASS && bus.reg_write && (bus.rd == bus.rt)) w_rd2 = bus.write_data;
      if (ZERO_REG && (bus.rt == '0))                     w_rd2 = '0;
   end

   // Effective busy: a retiring producer no longer blocks when its data is forwarded
   always_comb begin
      w_eb = r_busy;
      if (BYPASS && bus.reg_write) w_eb[bus.rd] = 1'b0;
      if (ZERO_REG)                w_eb[0]      = 1'b0;
   end

   assign w_stall  = bus.issue_valid &&
                     ((bus.rs_used  && w_eb[bus.rs]) ||
                      (bus.rt_used  && w_eb[bus.rt]) ||
                      (bus.issue_wr && w_eb[bus.issue_rd]));
   assign w_accept = bus.issue_valid && !w_stall;

   // Scoreboard update: flush over set over clear, so a new producer supersedes a retiring one
   always_comb begin
      w_busy_nxt = r_busy;
      if (bus.reg_write) w_busy_nxt[bus.rd] = 1'b0;
      if (w_accept && bus.issue_wr && !(ZERO_REG && (bus.issue_rd == '0)))
         w_busy_nxt[bus.issue_rd] = 1'b1;
      if (bus.flush) w_busy_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[bus.rd] <= bus.write_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   end

   assign bus.read_data1 = w_rd1;
   assign bus.read_data2 = w_rd2;
   assign bus.stall      = w_stall;
   assign bus.busy_vec   = r_busy;
endmodule
